// File: rtl/pcpi_issue_ctrl.sv
// PCPI initiator: issues one coprocessor instruction at a time and
// returns result plus OK/ILLEGAL/TIMEOUT status on a valid/ready port.
module pcpi_issue_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int BUSY_LIMIT  = 1024,
  parameter int CNT_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic [1:0]  rsp_status
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_ILL = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  generate
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT >= BUSY_LIMIT
        || (2 ** CNT_W) <= BUSY_LIMIT) begin : g_bad_params
      $error("pcpi_issue_ctrl: bad ACK_TIMEOUT/BUSY_LIMIT/CNT_W");
    end
  endgenerate

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [31:0]       insn_q, insn_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic              acked_q, acked_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic [1:0]        status_q, status_d;

  logic ack_expired;
  logic busy_expired;

  assign ack_expired  = !acked_q && (ack_cnt_q == ACK_LAST)
                        && !pcpi_wait;
  assign busy_expired = acked_q && (busy_cnt_q == BUSY_LAST);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    insn_d     = insn_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    ack_cnt_d  = ack_cnt_q;
    busy_cnt_d = busy_cnt_q;
    acked_d    = acked_q;
    data_d     = data_q;
    wr_d       = wr_q;
    status_d   = status_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          insn_d     = req_insn;
          rs1_d      = req_rs1;
          rs2_d      = req_rs2;
          valid_d    = 1'b1;
          ack_cnt_d  = '0;
          busy_cnt_d = '0;
          acked_d    = 1'b0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (busy_cnt_q != CNT_MAX) begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
        if (!acked_q && ack_cnt_q != CNT_MAX) begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
        if (pcpi_wait || pcpi_ready) begin
          acked_d = 1'b1;
        end

        // valid drops on the ready edge so the responder cannot restart
        if (pcpi_ready) begin
          data_d   = pcpi_wr ? pcpi_rd : 32'd0;
          wr_d     = pcpi_wr;
          status_d = ST_OK;
          valid_d  = 1'b0;
          state_d  = RESP;
        end else if (ack_expired) begin
          data_d   = 32'd0;
          wr_d     = 1'b0;
          status_d = ST_ILL;
          valid_d  = 1'b0;
          state_d  = RESP;
        end else if (busy_expired) begin
          data_d   = 32'd0;
          wr_d     = 1'b0;
          status_d = ST_TMO;
          valid_d  = 1'b0;
          state_d  = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      insn_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      ack_cnt_q  <= '0;
      busy_cnt_q <= '0;
      acked_q    <= 1'b0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      status_q   <= ST_OK;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      insn_q     <= insn_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      ack_cnt_q  <= ack_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      acked_q    <= acked_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      status_q   <= status_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign pcpi_valid = valid_q;
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = data_q;
  assign rsp_wr     = wr_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Bench for pcpi_issue_ctrl: behavioural PCPI responder plus a
// transaction-level outcome model, directed corners and random traffic.
module tb_pcpi_issue_ctrl;

  localparam int ACK_TO   = 16;
  localparam int BUSY_LIM = 1024;
  localparam int M_MUL    = 0;
  localparam int M_NONE   = 1;
  localparam int M_STUB   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic [1:0]  rsp_status;

  int n_chk  = 0;
  int n_fail = 0;

  int cfg_mode = M_MUL;
  int cfg_lat  = 0;
  int cfg_wa   = 0;
  bit cfg_wr   = 1'b1;
  bit force_ready = 1'b0;
  int rcnt;

  typedef struct {
    int          n;
    logic [1:0]  st;
    logic [31:0] d;
    logic        wr;
  } exp_t;

  always #5 clk = ~clk;

  pcpi_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_insn   (req_insn),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_wr     (rsp_wr),
    .rsp_status (rsp_status)
  );

  function automatic bit is_mul(input logic [31:0] insn);
    return insn[6:0] == 7'h33 && insn[31:25] == 7'h01 && !insn[14];
  endfunction

  function automatic logic [31:0] mul_res(input logic [31:0] insn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (insn[13:12] != 2'd3) ea = {{32{a[31]}}, a};
    if (insn[13:12] == 2'd1) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (insn[13:12] == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Responder: counts cycles of pcpi_valid, waits from cfg_wa, done at cfg_lat
  always @(posedge clk or posedge rst) begin
    if (rst) rcnt <= 0;
    else     rcnt <= pcpi_valid ? rcnt + 1 : 0;
  end

  always_comb begin
    logic w, r;
    w = 1'b0;
    r = 1'b0;
    pcpi_rd = 32'hDEAD_BEEF;
    pcpi_wr = 1'b1;
    if (pcpi_valid) begin
      if (cfg_mode == M_MUL && is_mul(pcpi_insn)) begin
        w = rcnt >= cfg_wa;
        r = rcnt == cfg_lat;
      end else if (cfg_mode == M_STUB) begin
        w = rcnt >= cfg_wa;
      end
    end
    if (r) begin
      pcpi_rd = mul_res(pcpi_insn, pcpi_rs1, pcpi_rs2);
      pcpi_wr = cfg_wr;
    end
    pcpi_wait  = w;
    pcpi_ready = r | force_ready;
  end

  function automatic exp_t model(input int mode, input int lat,
                                 input int wa, input bit wr,
                                 input logic [31:0] insn,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    int ack;
    bit mul;
    mul = (mode == M_MUL) && is_mul(insn);
    ack = 1 << 30;
    if (mul) ack = (wa < lat) ? wa : lat;
    else if (mode == M_STUB) ack = wa;
    e.d  = 32'd0;
    e.wr = 1'b0;
    if (ack >= ACK_TO) begin
      e.n  = ACK_TO;
      e.st = 2'd1;
    end else if (mul && lat < BUSY_LIM) begin
      e.n  = lat + 1;
      e.st = 2'd0;
      e.wr = wr;
      e.d  = wr ? mul_res(insn, a, b) : 32'd0;
    end else begin
      e.n  = BUSY_LIM;
      e.st = 2'd2;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge
  task automatic run_txn(input int mode, input int lat, input int wa,
                         input bit wr, input logic [31:0] insn,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit nxt,
                         input logic [31:0] ninsn,
                         input logic [31:0] na, input logic [31:0] nb,
                         input bit poke);
    exp_t e;
    int n, guard;
    bit stab;
    e = model(mode, lat, wa, wr, insn, a, b);
    cfg_mode = mode;
    cfg_lat  = lat;
    cfg_wa   = wa;
    cfg_wr   = wr;
    req_insn = insn;
    req_rs1  = a;
    req_rs2  = b;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_accept", 64'(guard < 50), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    stab = 1'b1;
    guard = 0;
    while (pcpi_valid && guard < 3000) begin
      n++;
      if (pcpi_insn !== insn || pcpi_rs1 !== a || pcpi_rs2 !== b
          || rsp_valid !== 1'b0 || req_ready !== 1'b0) stab = 1'b0;
      @(negedge clk);
      guard++;
    end
    chk("valid_cycles", 64'(n), 64'(e.n));
    chk("issue_stable", 64'(stab), 64'(1));
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_status", 64'(rsp_status), 64'(e.st));
    chk("rsp_data", 64'(rsp_data), 64'(e.d));
    chk("rsp_wr", 64'(rsp_wr), 64'(e.wr));
    stab = 1'b1;
    if (nxt) begin
      req_insn  = ninsn;
      req_rs1   = na;
      req_rs2   = nb;
      req_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) force_ready = 1'b1;
      @(negedge clk);
      force_ready = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_status !== e.st || rsp_data !== e.d
          || rsp_wr !== e.wr || req_ready !== 1'b0
          || pcpi_valid !== 1'b0) stab = 1'b0;
    end
    chk("rsp_hold", 64'(stab), 64'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (!nxt) req_valid = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'(0));
    chk("no_early_accept", 64'(pcpi_valid), 64'(0));
    chk("idle_ready", 64'(req_ready), 64'(1));
    if (poke) begin
      force_ready = 1'b1;
      @(negedge clk);
      force_ready = 1'b0;
      chk("idle_ignore", 64'({pcpi_valid, rsp_valid}), 64'(0));
    end
  endtask

  task automatic simple(input int mode, input int lat, input int wa,
                        input logic [31:0] insn,
                        input logic [31:0] a, input logic [31:0] b);
    run_txn(mode, lat, wa, 1'b1, insn, a, b, 0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ri, ra, rb;
    rst = 1'b1;
    req_valid = 1'b0;
    req_insn = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_pcpi_valid", 64'(pcpi_valid), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp", 64'({rsp_data, rsp_wr, rsp_status}), 64'(0));
    chk("rst_pcpi_bus", 64'({pcpi_insn, pcpi_rs1 | pcpi_rs2}), 64'(0));
    rst = 1'b0;
    #1;
    chk("rel_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);

    simple(M_MUL, 34, 0, 32'h02B5_0533, 32'd7, 32'd6);
    simple(M_MUL, 34, 0, 32'h02B5_3533, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    simple(M_NONE, 0, 0, 32'h0000_0013, 32'd1, 32'd2);
    run_txn(M_STUB, 0, 2, 1'b1, 32'h02B5_0533, 32'd3, 32'd4,
            5, 1'b0, 0, 0, 0, 1'b1);
    simple(M_MUL, 100, 15, 32'h02B5_0533, 32'd9, 32'd9);
    simple(M_MUL, 16, 16, 32'h02B5_0533, 32'd9, 32'd9);
    simple(M_MUL, 15, 99, 32'h02B5_0533, 32'd11, 32'd3);
    simple(M_MUL, 1023, 0, 32'h02B5_0533, 32'd8, 32'd8);
    simple(M_MUL, 1024, 0, 32'h02B5_0533, 32'd8, 32'd8);
    run_txn(M_MUL, 5, 0, 1'b0, 32'h02B5_0533, 32'd7, 32'd7,
            0, 1'b0, 0, 0, 0, 1'b0);

    run_txn(M_MUL, 34, 0, 1'b1, 32'h02B5_0533, 32'd7, 32'd6,
            10, 1'b1, 32'h02B5_0533, 32'd3, 32'd2, 1'b0);
    simple(M_MUL, 34, 0, 32'h02B5_0533, 32'd3, 32'd2);

    cfg_mode = M_MUL;
    cfg_lat  = 34;
    cfg_wa   = 0;
    req_insn = 32'h02B5_0533;
    req_rs1  = 32'd9;
    req_rs2  = 32'd9;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_issue_valid", 64'(pcpi_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_pcpi_valid", 64'(pcpi_valid), 64'(0));
    chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("arst_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    simple(M_MUL, 34, 0, 32'h02B5_0533, 32'd5, 32'd5);

    for (int k = 0; k < 40; k++) begin
      ri = {7'h01, 5'($urandom), 5'($urandom), 1'b0, 2'($urandom),
            5'($urandom), 7'h33};
      if ($urandom_range(0, 9) == 0) ri[14] = 1'b1;
      if ($urandom_range(0, 9) == 0) ri = 32'h0000_0013;
      ra = $urandom;
      rb = $urandom;
      run_txn(($urandom_range(0, 7) == 0) ? M_NONE : M_MUL,
              $urandom_range(0, 50), $urandom_range(0, 20),
              1'($urandom), ri, ra, rb, $urandom_range(0, 3),
              1'b0, 0, 0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
